// File: rtl/add_rs_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : add_rs_dispatch
// Brief    : ADD/SUB reservation station with CDB wakeup and a single-op
//            dispatcher feeding the add execution unit.
// Revision : 1.0 - initial release
// ============================================================================
module add_rs_dispatch #(
  parameter int DEPTH = 3,
  parameter int DW    = 8
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          alloc_valid,
  output logic          alloc_ready,
  input  logic [3:0]    alloc_func,
  input  logic [3:0]    alloc_rd,
  input  logic [2:0]    alloc_rob,
  input  logic          alloc_s1_rdy,
  input  logic [3:0]    alloc_s1_tag,
  input  logic [DW-1:0] alloc_s1_data,
  input  logic          alloc_s2_rdy,
  input  logic [3:0]    alloc_s2_tag,
  input  logic [DW-1:0] alloc_s2_data,
  input  logic          cdb_valid,
  input  logic [3:0]    cdb_tag,
  input  logic [DW-1:0] cdb_data,
  output logic          ex_b,
  output logic [2:0]    rs_index,
  output logic [DW-1:0] rs1_data,
  output logic [DW-1:0] rs2_data,
  output logic [3:0]    func,
  output logic [2:0]    rob_ind,
  output logic [3:0]    rd,
  input  logic          ex_done,
  input  logic [2:0]    ex_done_index,
  output logic [1:0]    count
);

  localparam int c_IDX_W = 3;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_EXEC = 1'b1} state_t;

  state_t r_state, w_state_nxt;

  logic [DEPTH-1:0] r_busy, r_disp, r_s1_rdy, r_s2_rdy;
  logic [3:0]       r_func   [DEPTH];
  logic [3:0]       r_rd     [DEPTH];
  logic [2:0]       r_rob    [DEPTH];
  logic [3:0]       r_s1_tag [DEPTH];
  logic [3:0]       r_s2_tag [DEPTH];
  logic [DW-1:0]    r_s1_data[DEPTH];
  logic [DW-1:0]    r_s2_data[DEPTH];

  logic             r_ex_b;
  logic [2:0]       r_rs_index, r_rob_ind;
  logic [DW-1:0]    r_rs1_data, r_rs2_data;
  logic [3:0]       r_func_o, r_rd_o;
  logic [1:0]       r_count;

  logic             w_alloc_hit, w_alloc_en, w_pick_hit, w_dispatch, w_free;
  logic [2:0]       w_alloc_idx, w_pick_idx, w_pick_rob;
  logic [3:0]       w_pick_func, w_pick_rd;
  logic [DW-1:0]    w_pick_s1, w_pick_s2;
  logic [DEPTH-1:0] w_s1_wake, w_s2_wake;
  logic             w_alloc_s1_hit, w_alloc_s2_hit;

  assign alloc_ready    = (int'(r_count) < DEPTH);
  assign w_alloc_en     = alloc_valid && alloc_ready && w_alloc_hit;
  assign w_alloc_s1_hit = cdb_valid && !alloc_s1_rdy && (alloc_s1_tag == cdb_tag);
  assign w_alloc_s2_hit = cdb_valid && !alloc_s2_rdy && (alloc_s2_tag == cdb_tag);

  // Descending scan so the lowest qualifying index wins.
  always_comb begin
    w_alloc_hit = 1'b0;
    w_alloc_idx = '0;
    w_pick_hit  = 1'b0;
    w_pick_idx  = '0;
    w_pick_s1   = '0;
    w_pick_s2   = '0;
    w_pick_func = '0;
    w_pick_rob  = '0;
    w_pick_rd   = '0;
    w_s1_wake   = '0;
    w_s2_wake   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_alloc_hit = 1'b1;
        w_alloc_idx = c_IDX_W'(i);
      end
      if (r_busy[i] && !r_disp[i] && r_s1_rdy[i] && r_s2_rdy[i]) begin
        w_pick_hit  = 1'b1;
        w_pick_idx  = c_IDX_W'(i);
        w_pick_s1   = r_s1_data[i];
        w_pick_s2   = r_s2_data[i];
        w_pick_func = r_func[i];
        w_pick_rob  = r_rob[i];
        w_pick_rd   = r_rd[i];
      end
      w_s1_wake[i] = cdb_valid && r_busy[i] && !r_s1_rdy[i] && (r_s1_tag[i] == cdb_tag);
      w_s2_wake[i] = cdb_valid && r_busy[i] && !r_s2_rdy[i] && (r_s2_tag[i] == cdb_tag);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dispatch  = 1'b0;
    w_free      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_hit) begin
          w_dispatch  = 1'b1;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (ex_done && (ex_done_index == r_rs_index)) begin
          w_free      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      r_busy   <= '0;
      r_disp   <= '0;
      r_s1_rdy <= '0;
      r_s2_rdy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_func[i]    <= '0;
        r_rd[i]      <= '0;
        r_rob[i]     <= '0;
        r_s1_tag[i]  <= '0;
        r_s2_tag[i]  <= '0;
        r_s1_data[i] <= '0;
        r_s2_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_alloc_en && (w_alloc_idx == c_IDX_W'(i))) begin
          // A broadcast in the allocation cycle is captured directly.
          r_busy[i]    <= 1'b1;
          r_disp[i]    <= 1'b0;
          r_func[i]    <= alloc_func;
          r_rd[i]      <= alloc_rd;
          r_rob[i]     <= alloc_rob;
          r_s1_rdy[i]  <= alloc_s1_rdy || w_alloc_s1_hit;
          r_s1_tag[i]  <= alloc_s1_tag;
          r_s1_data[i] <= w_alloc_s1_hit ? cdb_data : alloc_s1_data;
          r_s2_rdy[i]  <= alloc_s2_rdy || w_alloc_s2_hit;
          r_s2_tag[i]  <= alloc_s2_tag;
          r_s2_data[i] <= w_alloc_s2_hit ? cdb_data : alloc_s2_data;
        end else begin
          if (w_free && (r_rs_index == c_IDX_W'(i))) begin
            r_busy[i] <= 1'b0;
            r_disp[i] <= 1'b0;
          end
          if (w_dispatch && (w_pick_idx == c_IDX_W'(i))) r_disp[i] <= 1'b1;
          if (w_s1_wake[i]) begin
            r_s1_rdy[i]  <= 1'b1;
            r_s1_data[i] <= cdb_data;
          end
          if (w_s2_wake[i]) begin
            r_s2_rdy[i]  <= 1'b1;
            r_s2_data[i] <= cdb_data;
          end
        end
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      r_ex_b     <= 1'b0;
      r_rs_index <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_func_o   <= '0;
      r_rob_ind  <= '0;
      r_rd_o     <= '0;
    end else begin
      r_ex_b <= w_dispatch;
      if (w_dispatch) begin
        r_rs_index <= w_pick_idx;
        r_rs1_data <= w_pick_s1;
        r_rs2_data <= w_pick_s2;
        r_func_o   <= w_pick_func;
        r_rob_ind  <= w_pick_rob;
        r_rd_o     <= w_pick_rd;
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      case ({w_alloc_en, w_free})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign ex_b     = r_ex_b;
  assign rs_index = r_rs_index;
  assign rs1_data = r_rs1_data;
  assign rs2_data = r_rs2_data;
  assign func     = r_func_o;
  assign rob_ind  = r_rob_ind;
  assign rd       = r_rd_o;
  assign count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_add_rs_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_rs_dispatch
// Brief    : Scoreboard bench for add_rs_dispatch with a behavioural station model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_add_rs_dispatch;
  localparam int DEPTH = 3;
  localparam int DW    = 8;

  logic          clk1 = 1'b0;
  logic          rst  = 1'b1;
  logic          alloc_valid = 1'b0, alloc_ready;
  logic [3:0]    alloc_func = '0, alloc_rd = '0;
  logic [2:0]    alloc_rob = '0;
  logic          alloc_s1_rdy = 1'b0, alloc_s2_rdy = 1'b0;
  logic [3:0]    alloc_s1_tag = '0, alloc_s2_tag = '0;
  logic [DW-1:0] alloc_s1_data = '0, alloc_s2_data = '0;
  logic          cdb_valid = 1'b0;
  logic [3:0]    cdb_tag = '0;
  logic [DW-1:0] cdb_data = '0;
  logic          ex_b;
  logic [2:0]    rs_index, rob_ind;
  logic [DW-1:0] rs1_data, rs2_data;
  logic [3:0]    func, rd;
  logic          ex_done = 1'b0;
  logic [2:0]    ex_done_index = '0;
  logic [1:0]    count;

  add_rs_dispatch #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk1(clk1), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_func(alloc_func), .alloc_rd(alloc_rd), .alloc_rob(alloc_rob),
    .alloc_s1_rdy(alloc_s1_rdy), .alloc_s1_tag(alloc_s1_tag), .alloc_s1_data(alloc_s1_data),
    .alloc_s2_rdy(alloc_s2_rdy), .alloc_s2_tag(alloc_s2_tag), .alloc_s2_data(alloc_s2_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .ex_b(ex_b), .rs_index(rs_index), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .func(func), .rob_ind(rob_ind), .rd(rd),
    .ex_done(ex_done), .ex_done_index(ex_done_index), .count(count)
  );

  always #5 clk1 = ~clk1;

  typedef struct packed {
    logic       busy, disp;
    logic [3:0] func, rd;
    logic [2:0] rob;
    logic       r1, r2;
    logic [3:0] t1, t2;
    logic [7:0] d1, d2;
  } ent_t;

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] d1, d2;
    logic [3:0] func;
    logic [2:0] rob;
    logic [3:0] rd;
  } disp_t;

  int     n_checks = 0;
  int     n_fail   = 0;
  ent_t   m_e [DEPTH];
  ent_t   m_nx[DEPTH];
  bit     m_exec = 0;
  bit     m_exb  = 0;
  int     m_cur  = 0;
  int     m_count = 0;
  disp_t  m_last = '0;
  disp_t  exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: whole-station state advanced once per clock from the rules.
  always @(posedge clk1) begin : model
    int pick, aidx;
    bit fr, h1, h2;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_e[i] = '0;
      m_exec = 0; m_exb = 0; m_cur = 0; m_count = 0; m_last = '0;
      exp_q.delete();
    end else begin
      m_nx = m_e;
      fr = m_exec && ex_done && (int'(ex_done_index) == m_cur);
      pick = -1;
      if (!m_exec)
        for (int i = 0; i < DEPTH; i++)
          if (pick < 0 && m_e[i].busy && !m_e[i].disp && m_e[i].r1 && m_e[i].r2) pick = i;
      aidx = -1;
      if (alloc_valid && m_count < DEPTH)
        for (int i = 0; i < DEPTH; i++)
          if (aidx < 0 && !m_e[i].busy) aidx = i;
      for (int i = 0; i < DEPTH; i++) begin
        if (cdb_valid && m_e[i].busy && !m_e[i].r1 && m_e[i].t1 == cdb_tag) begin
          m_nx[i].r1 = 1; m_nx[i].d1 = cdb_data;
        end
        if (cdb_valid && m_e[i].busy && !m_e[i].r2 && m_e[i].t2 == cdb_tag) begin
          m_nx[i].r2 = 1; m_nx[i].d2 = cdb_data;
        end
      end
      if (fr) begin
        m_nx[m_cur].busy = 0;
        m_exec = 0;
        m_count--;
      end
      m_exb = 0;
      if (pick >= 0) begin
        m_nx[pick].disp = 1;
        m_exec = 1;
        m_cur  = pick;
        m_last = '{idx: 3'(pick), d1: m_e[pick].d1, d2: m_e[pick].d2,
                   func: m_e[pick].func, rob: m_e[pick].rob, rd: m_e[pick].rd};
        exp_q.push_back(m_last);
        m_exb = 1;
      end
      if (aidx >= 0) begin
        h1 = cdb_valid && !alloc_s1_rdy && alloc_s1_tag == cdb_tag;
        h2 = cdb_valid && !alloc_s2_rdy && alloc_s2_tag == cdb_tag;
        m_nx[aidx] = '{busy: 1, disp: 0, func: alloc_func, rd: alloc_rd, rob: alloc_rob,
                       r1: alloc_s1_rdy || h1, r2: alloc_s2_rdy || h2,
                       t1: alloc_s1_tag, t2: alloc_s2_tag,
                       d1: h1 ? cdb_data : alloc_s1_data, d2: h2 ? cdb_data : alloc_s2_data};
        m_count++;
      end
      m_e = m_nx;
    end
  end

  // Monitor: pops the scoreboard on every dispatch strobe.
  always @(negedge clk1) begin : monitor
    disp_t e;
    disp_t act;
    act = '{idx: rs_index, d1: rs1_data, d2: rs2_data, func: func, rob: rob_ind, rd: rd};
    chk("ex_b", 64'(ex_b), 64'(m_exb));
    if (ex_b) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL sb_unexpected: got dispatch %0h expected none", act);
      end else begin
        e = exp_q.pop_front();
        chk("dispatch", 64'(act), 64'(e));
      end
    end
    chk("count", 64'(count), 64'(m_count));
    chk("alloc_ready", 64'(alloc_ready), 64'(m_count < DEPTH));
    chk("held_outputs", 64'(act), 64'(m_last));
  end

  task automatic step();
    @(negedge clk1);
  endtask

  task automatic alloc(input logic [3:0] f, input logic [3:0] d, input logic [2:0] rob,
                       input logic r1, input logic [3:0] t1, input logic [7:0] d1,
                       input logic r2, input logic [3:0] t2, input logic [7:0] d2);
    alloc_valid = 1; alloc_func = f; alloc_rd = d; alloc_rob = rob;
    alloc_s1_rdy = r1; alloc_s1_tag = t1; alloc_s1_data = d1;
    alloc_s2_rdy = r2; alloc_s2_tag = t2; alloc_s2_data = d2;
    step();
    alloc_valid = 0;
  endtask

  task automatic cdb(input logic [3:0] t, input logic [7:0] d);
    cdb_valid = 1; cdb_tag = t; cdb_data = d;
    step();
    cdb_valid = 0;
  endtask

  task automatic done(input logic [2:0] idx);
    ex_done = 1; ex_done_index = idx;
    step();
    ex_done = 0;
  endtask

  task automatic expect_dispatch(input string name, input logic [2:0] idx,
                                 input logic [7:0] d1, input logic [7:0] d2,
                                 input logic [3:0] f, input logic [2:0] rob, input logic [3:0] d);
    int k;
    k = 0;
    while (!ex_b && k < 20) begin
      step();
      k++;
    end
    if (!ex_b) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: got no ex_b expected ex_b within 20 cycles", name);
    end else begin
      chk(name, {rs_index, rs1_data, rs2_data, func, rob_ind, rd}, {idx, d1, d2, f, rob, d});
    end
  endtask

  initial begin
    repeat (3) step();
    rst = 0;
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_ready", 64'(alloc_ready), 64'd1);
    chk("reset_outs", {ex_b, rs1_data, rs2_data, rd}, 64'd0);

    // Basic ADD with both operands ready
    alloc(4'b0000, 4'd3, 3'd2, 1, 4'd0, 8'h05, 1, 4'd0, 8'h07);
    chk("t1_ex_b_not_yet", 64'(ex_b), 64'd0);
    step();
    chk("t1_latency", 64'(ex_b), 64'd1);
    expect_dispatch("t1_disp", 3'd0, 8'h05, 8'h07, 4'b0000, 3'd2, 4'd3);
    done(3'd0);
    chk("t1_ex_b_pulse", 64'(ex_b), 64'd0);
    chk("t1_count", 64'(count), 64'd0);

    // SUB waiting on tag 4
    alloc(4'b0001, 4'd5, 3'd1, 1, 4'd0, 8'h01, 0, 4'd4, 8'h00);
    cdb(4'd4, 8'h10);
    expect_dispatch("t2_wakeup", 3'd0, 8'h01, 8'h10, 4'b0001, 3'd1, 4'd5);
    done(3'd0);

    // Fill, overflow attempt, ordered dispatch
    alloc(4'b0000, 4'd1, 3'd0, 0, 4'd9, 8'h00, 1, 4'd0, 8'h11);
    alloc(4'b0001, 4'd2, 3'd1, 0, 4'd9, 8'h00, 1, 4'd0, 8'h22);
    alloc(4'b0000, 4'd7, 3'd2, 0, 4'd9, 8'h00, 1, 4'd0, 8'h44);
    chk("t3_full_count", 64'(count), 64'd3);
    chk("t3_full_ready", 64'(alloc_ready), 64'd0);
    alloc(4'b0001, 4'd8, 3'd3, 1, 4'd0, 8'h55, 1, 4'd0, 8'h66);
    chk("t3_overflow_count", 64'(count), 64'd3);
    cdb(4'd9, 8'h33);
    expect_dispatch("t3_first", 3'd0, 8'h33, 8'h11, 4'b0000, 3'd0, 4'd1);
    step(); step();
    chk("t3_entry1_waits", 64'(ex_b), 64'd0);
    done(3'd1);
    chk("t3_bad_idx_ignored", 64'(count), 64'd3);
    done(3'd0);
    chk("t3_free_ready", 64'(alloc_ready), 64'd1);
    chk("t3_free_count", 64'(count), 64'd2);
    expect_dispatch("t3_second", 3'd1, 8'h33, 8'h22, 4'b0001, 3'd1, 4'd2);
    done(3'd1);
    expect_dispatch("t3_third", 3'd2, 8'h33, 8'h44, 4'b0000, 3'd2, 4'd7);
    done(3'd2);
    chk("t3_drained", 64'(count), 64'd0);

    // Same-cycle allocation and broadcast
    cdb_valid = 1; cdb_tag = 4'd6; cdb_data = 8'hAA;
    alloc(4'b1010, 4'd6, 3'd5, 0, 4'd6, 8'h00, 1, 4'd0, 8'h02);
    cdb_valid = 0;
    expect_dispatch("t4_same_cycle", 3'd0, 8'hAA, 8'h02, 4'b1010, 3'd5, 4'd6);
    done(3'd0);

    // Reset while executing
    alloc(4'b0000, 4'd9, 3'd4, 1, 4'd0, 8'h12, 1, 4'd0, 8'h34);
    expect_dispatch("t5_disp", 3'd0, 8'h12, 8'h34, 4'b0000, 3'd4, 4'd9);
    rst = 1;
    step();
    rst = 0;
    chk("t5_rst_count", 64'(count), 64'd0);
    chk("t5_rst_outs", {ex_b, rs1_data, rs2_data, func, rob_ind, rd}, 64'd0);
    done(3'd0);
    chk("t5_stale_done_count", 64'(count), 64'd0);
    chk("t5_stale_done_exb", 64'(ex_b), 64'd0);

    // Randomised traffic
    for (int c = 0; c < 3000; c++) begin
      rst           = ($urandom_range(0, 499) == 0);
      alloc_valid   = $urandom_range(0, 1);
      alloc_func    = 4'($urandom_range(0, 15));
      alloc_rd      = 4'($urandom_range(0, 15));
      alloc_rob     = 3'($urandom_range(0, 7));
      alloc_s1_rdy  = $urandom_range(0, 2) != 0;
      alloc_s1_tag  = 4'($urandom_range(0, 3));
      alloc_s1_data = 8'($urandom);
      alloc_s2_rdy  = $urandom_range(0, 2) != 0;
      alloc_s2_tag  = 4'($urandom_range(0, 3));
      alloc_s2_data = 8'($urandom);
      cdb_valid     = $urandom_range(0, 2) == 0;
      cdb_tag       = 4'($urandom_range(0, 4));
      cdb_data      = 8'($urandom);
      ex_done       = $urandom_range(0, 2) == 0;
      ex_done_index = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(0, 3)) : 3'(m_cur);
      step();
    end
    rst = 0; alloc_valid = 0; cdb_valid = 0; ex_done = 0;
    step(); step();
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
